// File: rtl/interboard_pkg.sv
// Shared definitions for the board-to-board 4-phase Request/Ack link.
// Used by both the sender (send_all) and the receiver (receive_all).
package interboard_pkg;

  localparam int unsigned WORD_W    = 6;
  localparam int unsigned FRAME_LEN = 6;
  localparam logic [WORD_W-1:0] RST_WORD     = 6'h3F;
  localparam logic [WORD_W-1:0] MSG_TYPE_MAX = 6'd15;

  localparam int unsigned MSG_W  = 4;
  localparam int unsigned BX_W   = 5;
  localparam int unsigned BY_W   = 3;
  localparam int unsigned CARD_W = 6;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned DIR_W  = 1;

  localparam logic [MSG_W-1:0] MSG_NONE   = 4'h0;
  localparam logic [MSG_W-1:0] MSG_PLACE  = 4'h1;
  localparam logic [MSG_W-1:0] MSG_SELECT = 4'h2;
  localparam logic [MSG_W-1:0] MSG_MOVE   = 4'h3;

  typedef struct packed {
    logic [MSG_W-1:0]  msg_type;
    logic [BX_W-1:0]   block_x;
    logic [BY_W-1:0]   block_y;
    logic [CARD_W-1:0] card;
    logic [SEL_W-1:0]  sel_len;
    logic [DIR_W-1:0]  move_dir;
  } frame_t;

  typedef enum logic [1:0] {StIdle, StWord, StPeerRst} frame_state_e;
  typedef enum logic [1:0] {WReq, WAck, WHold} word_state_e;

endpackage

// File: rtl/receive_single.sv
// One-word responder: synchronises Request/data, waits for a settled Request,
// captures the word and runs the Ack half of the 4-phase handshake.
module receive_single
  import interboard_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              request,
  input  logic [WORD_W-1:0] data,
  input  logic              rst_detect_en,
  output logic              ack,
  output logic              word_valid,
  output logic [WORD_W-1:0] word,
  output logic              word_done,
  output logic              req_sync
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] req_ff;
  logic [WORD_W-1:0]      data_ff [SYNC_STAGES];
  logic [CNT_W-1:0]       settle;
  word_state_e            state;
  logic                   req_s;
  logic [WORD_W-1:0]      data_s;

  assign req_s    = req_ff[SYNC_STAGES-1];
  assign data_s   = data_ff[SYNC_STAGES-1];
  assign req_sync = req_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ff <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) data_ff[i] <= '0;
    end else begin
      req_ff     <= {req_ff[SYNC_STAGES-2:0], request};
      data_ff[0] <= data;
      for (int i = 1; i < SYNC_STAGES; i++) data_ff[i] <= data_ff[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WReq;
      settle     <= '0;
      ack        <= 1'b0;
      word_valid <= 1'b0;
      word_done  <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      word_done  <= 1'b0;
      case (state)
        WReq: begin
          if (req_s) begin
            if (settle == SETTLE_LAST) begin
              settle     <= '0;
              word       <= data_s;
              word_valid <= 1'b1;
              // A peer-reset word at frame start is never acknowledged.
              if (rst_detect_en && data_s == RST_WORD) begin
                state <= WHold;
              end else begin
                ack   <= 1'b1;
                state <= WAck;
              end
            end else begin
              settle <= settle + 1'b1;
            end
          end else begin
            settle <= '0;
          end
        end
        WAck: begin
          if (!req_s) begin
            ack       <= 1'b0;
            word_done <= 1'b1;
            state     <= WReq;
          end
        end
        WHold: begin
          if (!req_s) state <= WReq;
        end
        default: state <= WReq;
      endcase
    end
  end

endmodule

// File: rtl/receive_all.sv
// Inter-board receiver: assembles six handshaken words into a frame for
// GameControl, detects the peer reset word and aborts stalled frames.
module receive_all
  import interboard_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned TIMEOUT       = 50_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Request,
  input  logic [WORD_W-1:0] interboard_data,
  output logic              Ack,
  output logic              rx_en,
  output logic [MSG_W-1:0]  rx_msg_type,
  output logic [BX_W-1:0]   rx_block_x,
  output logic [BY_W-1:0]   rx_block_y,
  output logic [CARD_W-1:0] rx_card,
  output logic [SEL_W-1:0]  rx_sel_len,
  output logic [DIR_W-1:0]  rx_move_dir,
  output logic              rx_peer_rst,
  output logic              rx_error
);

  localparam logic [31:0] TMO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);
  localparam logic [2:0]  K_LAST   = 3'(FRAME_LEN - 1);

  logic              word_valid;
  logic              word_done;
  logic              req_s;
  logic [WORD_W-1:0] word;
  frame_state_e      state;
  logic [2:0]        k;
  frame_t            shadow;
  frame_t            out_q;
  logic [31:0]       tmo_cnt;
  logic              counting;
  logic              tmo_hit;

  receive_single #(
    .SYNC_STAGES  (SYNC_STAGES),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_single (
    .clk          (clk),
    .rst_n        (rst_n),
    .request      (Request),
    .data         (interboard_data),
    .rst_detect_en(state == StIdle),
    .ack          (Ack),
    .word_valid   (word_valid),
    .word         (word),
    .word_done    (word_done),
    .req_sync     (req_s)
  );

  // Only idle gaps between words of a started frame count towards the timeout.
  assign counting = (state == StWord) && (k != 3'd0) && !req_s && !word_done;
  assign tmo_hit  = (TIMEOUT != 0) && counting && (tmo_cnt >= TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= StIdle;
      k           <= '0;
      shadow      <= '0;
      out_q       <= '0;
      tmo_cnt     <= '0;
      rx_en       <= 1'b0;
      rx_peer_rst <= 1'b0;
      rx_error    <= 1'b0;
    end else begin
      rx_en       <= 1'b0;
      rx_peer_rst <= 1'b0;
      rx_error    <= 1'b0;
      case (state)
        StIdle: begin
          k       <= '0;
          tmo_cnt <= '0;
          if (word_valid) begin
            if (word == RST_WORD) begin
              rx_peer_rst <= 1'b1;
              state       <= StPeerRst;
            end else if (word > MSG_TYPE_MAX) begin
              rx_error <= 1'b1;
            end else begin
              shadow.msg_type <= word[MSG_W-1:0];
              state           <= StWord;
            end
          end
        end
        StWord: begin
          if (word_valid) begin
            case (k)
              3'd1:    shadow.block_x  <= word[BX_W-1:0];
              3'd2:    shadow.block_y  <= word[BY_W-1:0];
              3'd3:    shadow.card     <= word[CARD_W-1:0];
              3'd4:    shadow.sel_len  <= word[SEL_W-1:0];
              3'd5:    shadow.move_dir <= word[DIR_W-1:0];
              default: ;
            endcase
          end
          if (word_done) begin
            tmo_cnt <= '0;
            if (k == K_LAST) begin
              rx_en <= 1'b1;
              out_q <= shadow;
              state <= StIdle;
            end else begin
              k <= k + 3'd1;
            end
          end else if (tmo_hit) begin
            rx_error <= 1'b1;
            state    <= StIdle;
          end else if (counting && tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        StPeerRst: begin
          if (!req_s) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign rx_msg_type = out_q.msg_type;
  assign rx_block_x  = out_q.block_x;
  assign rx_block_y  = out_q.block_y;
  assign rx_card     = out_q.card;
  assign rx_sel_len  = out_q.sel_len;
  assign rx_move_dir = out_q.move_dir;

endmodule

// File: tb/tb_receive_all.sv
// Scoreboard bench for receive_all: a 4-phase peer model drives words, expected
// events are queued, and a negedge monitor pops and compares every output pulse.
`timescale 1ns/1ps
module tb_receive_all;

  localparam int unsigned TMO = 100;
  localparam logic [1:0] K_EN = 2'd0, K_PRST = 2'd1, K_ERR = 2'd2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       Request = 1'b0;
  logic [5:0] interboard_data = 6'd0;
  logic       Ack, rx_en, rx_peer_rst, rx_error;
  logic [3:0] rx_msg_type;
  logic [4:0] rx_block_x;
  logic [2:0] rx_block_y;
  logic [5:0] rx_card;
  logic [2:0] rx_sel_len;
  logic [0:0] rx_move_dir;

  always #5 clk = ~clk;

  receive_all #(
    .SYNC_STAGES  (2),
    .SETTLE_CYCLES(2),
    .TIMEOUT      (TMO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .Request        (Request),
    .interboard_data(interboard_data),
    .Ack            (Ack),
    .rx_en          (rx_en),
    .rx_msg_type    (rx_msg_type),
    .rx_block_x     (rx_block_x),
    .rx_block_y     (rx_block_y),
    .rx_card        (rx_card),
    .rx_sel_len     (rx_sel_len),
    .rx_move_dir    (rx_move_dir),
    .rx_peer_rst    (rx_peer_rst),
    .rx_error       (rx_error)
  );

  typedef struct packed {
    logic [1:0]  kind;
    logic [21:0] fields;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [21:0] model_f = '0;
  logic [21:0] out_bus;
  int          total = 0, bad = 0, cyc = 0, err_cyc = -1, n_ev;
  logic [1:0]  cur;

  assign out_bus = {rx_msg_type, rx_block_x, rx_block_y, rx_card, rx_sel_len, rx_move_dir};

  always @(posedge clk) cyc++;

  // Monitor: every output pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_f = '0;
    end else begin
      n_ev = 0;
      if (rx_en) n_ev++;
      if (rx_peer_rst) n_ev++;
      if (rx_error) n_ev++;
      total++;
      if (n_ev > 1) begin
        bad++;
        $display("FAIL pulse_exclusive got en=%0b prst=%0b err=%0b want at most one",
                 rx_en, rx_peer_rst, rx_error);
      end
      if (n_ev != 0) begin
        total++;
        cur = rx_en ? K_EN : (rx_peer_rst ? K_PRST : K_ERR);
        if (cur == K_ERR) err_cyc = cyc;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event got kind=%0d want none (cycle %0d)", cur, cyc);
        end else begin
          e = exp_q.pop_front();
          if (cur != e.kind) begin
            bad++;
            $display("FAIL event_kind got=%0d want=%0d (cycle %0d)", cur, e.kind, cyc);
          end else if (cur == K_EN) begin
            total++;
            if (out_bus !== e.fields) begin
              bad++;
              $display("FAIL frame_fields got=%06h want=%06h", out_bus, e.fields);
            end
            model_f = e.fields;
          end
        end
      end
      if (!rx_en) begin
        total++;
        if (out_bus !== model_f) begin
          bad++;
          $display("FAIL fields_hold got=%06h want=%06h (cycle %0d)", out_bus, model_f, cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic [3:0] mt, input logic [4:0] bx,
                      input logic [2:0] by, input logic [5:0] cd, input logic [2:0] sl,
                      input logic md);
    exp_t x;
    x.kind   = kind;
    x.fields = {mt, bx, by, cd, sl, md};
    exp_q.push_back(x);
  endtask

  task automatic wait_ack(input logic val, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (Ack === val) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic req_up(input logic [5:0] w);
    @(negedge clk);
    check("ack_low_before_req", 32'(Ack), 32'd0);
    interboard_data = w;
    Request = 1'b1;
    wait_ack(1'b1, "ack_rise");
  endtask

  task automatic req_down();
    Request = 1'b0;
    wait_ack(1'b0, "ack_fall");
  endtask

  task automatic send_word(input logic [5:0] w);
    req_up(w);
    req_down();
  endtask

  task automatic send_frame(input logic [5:0] w0, input logic [5:0] w1, input logic [5:0] w2,
                            input logic [5:0] w3, input logic [5:0] w4, input logic [5:0] w5);
    send_word(w0); send_word(w1); send_word(w2);
    send_word(w3); send_word(w4); send_word(w5);
  endtask

  initial begin
    bit saw_ack;
    int t0;
    bit seen;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_ack", 32'(Ack), 32'd0);
    check("reset_pulses", {29'd0, rx_en, rx_peer_rst, rx_error}, 32'd0);
    check("reset_fields", 32'(out_bus), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: basic frame
    push(K_EN, 4'h3, 5'd17, 3'd5, 6'd42, 3'd2, 1'b1);
    send_frame(6'd3, 6'd17, 6'd5, 6'd42, 6'd2, 6'd1);
    repeat (4) @(negedge clk);

    // 2: peer reset word, never acknowledged
    push(K_PRST, '0, '0, '0, '0, '0, 1'b0);
    @(negedge clk);
    check("ack_low_before_prst", 32'(Ack), 32'd0);
    interboard_data = 6'h3F;
    Request = 1'b1;
    saw_ack = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (Ack) saw_ack = 1'b1;
    end
    check("prst_ack_held_low", 32'(saw_ack), 32'd0);
    Request = 1'b0;
    repeat (6) @(negedge clk);
    push(K_EN, 4'h1, 5'd3, 3'd2, 6'd7, 3'd1, 1'b0);
    send_frame(6'd1, 6'd3, 6'd2, 6'd7, 6'd1, 6'd0);
    repeat (4) @(negedge clk);

    // 3: bad msg_type still acked; next frame's upper bits are truncated
    push(K_ERR, '0, '0, '0, '0, '0, 1'b0);
    send_word(6'd20);
    push(K_EN, 4'h2, 5'd31, 3'd7, 6'd63, 3'd7, 1'b0);
    send_frame(6'd2, 6'h3F, 6'h2F, 6'h3F, 6'h3F, 6'h3E);
    repeat (4) @(negedge clk);

    // 4: stall after word 3 -> timeout
    err_cyc = -1;
    push(K_ERR, '0, '0, '0, '0, '0, 1'b0);
    send_word(6'd5); send_word(6'd10); send_word(6'd1); send_word(6'd20);
    t0 = cyc;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (err_cyc >= 0) begin
        seen = 1'b1;
        break;
      end
    end
    check("timeout_seen", 32'(seen), 32'd1);
    if (seen) begin
      total++;
      if (err_cyc - t0 < 99 || err_cyc - t0 > 103) begin
        bad++;
        $display("FAIL timeout_delay got=%0d want=99..103", err_cyc - t0);
      end
    end
    push(K_EN, 4'h4, 5'd8, 3'd3, 6'd9, 3'd4, 1'b0);
    send_frame(6'd4, 6'd8, 6'd3, 6'd9, 6'd4, 6'd0);
    repeat (4) @(negedge clk);

    // 5: reset during word 2 Ack-high phase
    send_word(6'd6); send_word(6'd12);
    req_up(6'd6);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_ack", 32'(Ack), 32'd0);
    check("midreset_pulses", {29'd0, rx_en, rx_peer_rst, rx_error}, 32'd0);
    check("midreset_fields", 32'(out_bus), 32'd0);
    @(negedge clk);
    Request = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    push(K_EN, 4'h6, 5'd12, 3'd6, 6'd33, 3'd5, 1'b1);
    send_frame(6'd6, 6'd12, 6'd6, 6'd33, 6'd5, 6'd1);

    // 6: back-to-back frames with 0x3F as card data
    push(K_EN, 4'h7, 5'd1, 3'd4, 6'h3F, 3'd3, 1'b0);
    push(K_EN, 4'h8, 5'd30, 3'd0, 6'h3F, 3'd6, 1'b1);
    send_frame(6'd7, 6'd1, 6'd4, 6'h3F, 6'd3, 6'd0);
    send_frame(6'd8, 6'd30, 6'd0, 6'h3F, 6'd6, 6'd1);
    repeat (20) @(negedge clk);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog expired got=running want=finished");
    $fatal(1);
  end

endmodule
